// File: rtl/tx_axis_arbiter.sv
// Frame-atomic AXI-Stream arbiter: shares the MAC TX stream among NUM_PORTS requesters, round-robin by default.
// Latency: one idle arbitration cycle before each frame, then a zero-latency combinational forward of the granted port.
// Backpressure: m_axis_tready is forwarded to the granted port only; every other requester sees tready=0 and holds its data.
//
// Ports:
//   sys_clk, sys_rst_n          clock, asynchronous active-low reset
//   s_axis_t*                   packed per-port slave streams (port i = slice i)
//   m_axis_t*                   single master stream to the MAC
//   grant_valid / grant_idx     BUSY indication and current or last granted port
//   frame_done                  one-cycle pulse the cycle after a tlast handshake
//   stat_frames                 per-port 16-bit completed-frame counters (slice i = port i), wrapping
// Optional build macro: TX_ARB_STRICT_PRIO_EN gives port 0 strict priority over the round-robin ports.
module tx_axis_arbiter #(
    parameter int NUM_PORTS       = 3,
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int AXIS_DATA_BYTES = AXIS_DATA_WIDTH / 8,
    parameter int IDX_WIDTH       = 2
) (
    input  logic                                 sys_clk,
    input  logic                                 sys_rst_n,
    input  logic [NUM_PORTS*AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS*AXIS_DATA_BYTES-1:0] s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]                 s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]                 s_axis_tlast,
    output logic [NUM_PORTS-1:0]                 s_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0]           m_axis_tdata,
    output logic [AXIS_DATA_BYTES-1:0]           m_axis_tkeep,
    output logic                                 m_axis_tvalid,
    output logic                                 m_axis_tlast,
    input  logic                                 m_axis_tready,
    output logic                                 grant_valid,
    output logic [IDX_WIDTH-1:0]                 grant_idx,
    output logic                                 frame_done,
    output logic [NUM_PORTS*16-1:0]              stat_frames
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [IDX_WIDTH-1:0]    r_rr_ptr;
    logic [IDX_WIDTH-1:0]    w_rr_nxt;
    logic [IDX_WIDTH-1:0]    r_grant_idx;
    logic [IDX_WIDTH-1:0]    w_winner;
    logic                    w_any;
    logic [IDX_WIDTH:0]      w_cand;
    logic [NUM_PORTS-1:0]    w_req;
    logic                    w_end;
    logic                    r_frame_done;
    logic [NUM_PORTS*16-1:0] r_stat_frames;

`ifdef TX_ARB_STRICT_PRIO_EN
    // Port 0 is handled outside the rotation, so it is masked from the round-robin search.
    assign w_req = s_axis_tvalid & {{(NUM_PORTS-1){1'b1}}, 1'b0};
`else
    assign w_req = s_axis_tvalid;
`endif

    // Round-robin search starting at r_rr_ptr; the candidate index is wrapped by
    // subtraction because NUM_PORTS need not be a power of two.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_cand = {1'b0, r_rr_ptr} + (IDX_WIDTH+1)'(k);
            if (w_cand >= (IDX_WIDTH+1)'(NUM_PORTS)) begin
                w_cand = w_cand - (IDX_WIDTH+1)'(NUM_PORTS);
            end
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!w_any && w_req[i] && (w_cand == (IDX_WIDTH+1)'(i))) begin
                    w_any    = 1'b1;
                    w_winner = IDX_WIDTH'(i);
                end
            end
        end
`ifdef TX_ARB_STRICT_PRIO_EN
        if (s_axis_tvalid[0]) begin
            w_any    = 1'b1;
            w_winner = '0;
        end
`endif
    end

    // Combinational forward of the granted port. An out-of-range grant matches no
    // port and therefore leaves every output at zero.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        if (r_state == BUSY) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (r_grant_idx == IDX_WIDTH'(i)) begin
                    m_axis_tdata     = s_axis_tdata[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
                    m_axis_tkeep     = s_axis_tkeep[i*AXIS_DATA_BYTES +: AXIS_DATA_BYTES];
                    m_axis_tvalid    = s_axis_tvalid[i];
                    m_axis_tlast     = s_axis_tlast[i];
                    s_axis_tready[i] = m_axis_tready;
                end
            end
        end
    end

    assign w_end = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    // Next-state and pointer update.
    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (w_end) begin
                    w_state_nxt = IDLE;
                    if (r_grant_idx >= IDX_WIDTH'(NUM_PORTS-1)) begin
                        w_rr_nxt = '0;
                    end else begin
                        w_rr_nxt = r_grant_idx + 1'b1;
                    end
`ifdef TX_ARB_STRICT_PRIO_EN
                    // Priority grants do not consume a round-robin turn.
                    if (r_grant_idx == '0) begin
                        w_rr_nxt = r_rr_ptr;
                    end
`endif
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state       <= IDLE;
            r_rr_ptr      <= '0;
            r_grant_idx   <= '0;
            r_frame_done  <= 1'b0;
            r_stat_frames <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rr_ptr     <= w_rr_nxt;
            r_frame_done <= w_end;
            if (r_state == IDLE && w_any) begin
                r_grant_idx <= w_winner;
            end
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_end && r_grant_idx == IDX_WIDTH'(i)) begin
                    r_stat_frames[i*16 +: 16] <= r_stat_frames[i*16 +: 16] + 16'd1;
                end
            end
        end
    end

    assign grant_valid = (r_state == BUSY);
    assign grant_idx   = r_grant_idx;
    assign frame_done  = r_frame_done;
    assign stat_frames = r_stat_frames;

endmodule

// File: tb/tb_tx_axis_arbiter.sv
// Self-checking bench for tx_axis_arbiter: per-port source queues drive the slave
// streams, expected master beats are queued in grant order and popped on handshake.
module tb_tx_axis_arbiter;

    localparam int NP = 3;
    localparam int DW = 64;
    localparam int DB = 8;
    localparam int IW = 2;

    logic             sys_clk = 1'b0;
    logic             sys_rst_n;
    logic [NP*DW-1:0] s_axis_tdata;
    logic [NP*DB-1:0] s_axis_tkeep;
    logic [NP-1:0]    s_axis_tvalid;
    logic [NP-1:0]    s_axis_tlast;
    logic [NP-1:0]    s_axis_tready;
    logic [DW-1:0]    m_axis_tdata;
    logic [DB-1:0]    m_axis_tkeep;
    logic             m_axis_tvalid;
    logic             m_axis_tlast;
    logic             m_axis_tready;
    logic             grant_valid;
    logic [IW-1:0]    grant_idx;
    logic             frame_done;
    logic [NP*16-1:0] stat_frames;

    always #5 sys_clk = ~sys_clk;

    tx_axis_arbiter #(
        .NUM_PORTS(NP), .AXIS_DATA_WIDTH(DW), .AXIS_DATA_BYTES(DB), .IDX_WIDTH(IW)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .grant_valid(grant_valid), .grant_idx(grant_idx),
        .frame_done(frame_done), .stat_frames(stat_frames)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [DB-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [IW-1:0] port;
        beat_t         b;
    } exp_t;

    typedef struct packed {
        logic [NP-1:0]        mask;
        int                   nfr;
        int                   nb;
        int                   ord_n;
        logic [5:0][IW-1:0]   ord;
    } vec_t;

    beat_t       src_mem [NP][256];
    int          src_head [NP];
    int          src_tail [NP];
    logic [NP-1:0] gap;
    logic [NP-1:0] hs;
    logic        mt_rdy;
    logic        sb_on;
    logic        prev_last;
    exp_t        sb_q[$];
    vec_t        vt[6];
    int          exp_stat [NP];
    int          checks;
    int          failures;
    int          fd_count;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mkdata(input int p, input int fid, input int b);
        return {16'(p), 16'(fid), 32'(b)};
    endfunction

    function automatic logic [5:0][IW-1:0] ord6(input int a, input int b, input int c,
                                                input int d, input int e, input int f);
        logic [5:0][IW-1:0] r;
        r[0] = IW'(a); r[1] = IW'(b); r[2] = IW'(c);
        r[3] = IW'(d); r[4] = IW'(e); r[5] = IW'(f);
        return r;
    endfunction

    function automatic vec_t mkvec(input logic [NP-1:0] mask, input int nfr, input int nb,
                                   input int ord_n, input logic [5:0][IW-1:0] ord);
        vec_t v;
        v.mask = mask; v.nfr = nfr; v.nb = nb; v.ord_n = ord_n; v.ord = ord;
        return v;
    endfunction

    task automatic push_beat(input int p, input logic [DW-1:0] d, input logic [DB-1:0] k, input logic l);
        src_mem[p][src_tail[p]] = '{data: d, keep: k, last: l};
        src_tail[p]++;
    endtask

    task automatic push_frame(input int p, input int fid, input int nb);
        for (int b = 0; b < nb; b++)
            push_beat(p, mkdata(p, fid, b), (b == nb-1) ? 8'h0F : 8'hFF, b == nb-1);
    endtask

    task automatic sb_frame(input int p, input int fid, input int nb);
        exp_t e;
        for (int b = 0; b < nb; b++) begin
            e.port   = IW'(p);
            e.b.data = mkdata(p, fid, b);
            e.b.keep = (b == nb-1) ? 8'h0F : 8'hFF;
            e.b.last = (b == nb-1);
            sb_q.push_back(e);
        end
    endtask

    // One clock: drive sources just after the rising edge, observe at the falling edge.
    task automatic tick();
        exp_t e;
        @(posedge sys_clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (hs[i]) src_head[i]++;
            if (src_head[i] != src_tail[i] && !gap[i]) begin
                s_axis_tvalid[i]         = 1'b1;
                s_axis_tdata[i*DW +: DW] = src_mem[i][src_head[i]].data;
                s_axis_tkeep[i*DB +: DB] = src_mem[i][src_head[i]].keep;
                s_axis_tlast[i]          = src_mem[i][src_head[i]].last;
            end else begin
                s_axis_tvalid[i]         = 1'b0;
                s_axis_tdata[i*DW +: DW] = '0;
                s_axis_tkeep[i*DB +: DB] = '0;
                s_axis_tlast[i]          = 1'b0;
            end
        end
        m_axis_tready = mt_rdy;
        @(negedge sys_clk);
        hs = s_axis_tvalid & s_axis_tready;
        if (!sys_rst_n) begin
            prev_last = 1'b0;
        end else begin
            if (prev_last) begin
                chk("frame_done_after_tlast", frame_done, 1);
                chk("idle_gap_after_frame", m_axis_tvalid, 0);
            end else if (frame_done) begin
                chk("frame_done_spurious", frame_done, 0);
            end
            if (frame_done) fd_count++;
            if (m_axis_tvalid && m_axis_tready && sb_on) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected_beat: got port %0d data %h, expected no beat", grant_idx, m_axis_tdata);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_beat", {grant_idx, m_axis_tdata, m_axis_tkeep, m_axis_tlast},
                        {e.port, e.b.data, e.b.keep, e.b.last});
                end
            end
            prev_last = m_axis_tvalid && m_axis_tready && m_axis_tlast;
        end
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || grant_valid) && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_drain_in_budget"}, n < budget, 1);
        tick();
        tick();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_m_tvalid"}, m_axis_tvalid, 0);
        chk({tag, "_s_tready"}, s_axis_tready, 0);
        chk({tag, "_grant_valid"}, grant_valid, 0);
        chk({tag, "_grant_idx"}, grant_idx, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_stat_frames"}, stat_frames, 0);
    endtask

    // Asserted between clock edges; outputs must clear without waiting for a clock.
    task automatic async_reset(input string tag);
        #2 sys_rst_n = 1'b0;
        #1 chk_zero(tag);
        for (int i = 0; i < NP; i++) src_tail[i] = src_head[i];
        hs = '0;
        s_axis_tvalid = '0;
        tick();
        tick();
        sys_rst_n = 1'b1;
        tick();
    endtask

    task automatic chk_stats(input string tag);
        for (int p = 0; p < NP; p++)
            chk($sformatf("%s_stat%0d", tag, p), stat_frames[p*16 +: 16], 16'(exp_stat[p]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt [NP];
        int beats;

`ifdef TX_ARB_STRICT_PRIO_EN
        vt[0] = mkvec(3'b111, 2, 2, 6, ord6(0, 0, 1, 2, 1, 2));
        vt[1] = mkvec(3'b110, 1, 1, 2, ord6(1, 2, 0, 0, 0, 0));
        vt[2] = mkvec(3'b101, 1, 3, 2, ord6(0, 2, 0, 0, 0, 0));
        vt[3] = mkvec(3'b011, 2, 1, 4, ord6(0, 0, 1, 1, 0, 0));
        vt[4] = mkvec(3'b001, 1, 2, 1, ord6(0, 0, 0, 0, 0, 0));
        vt[5] = mkvec(3'b111, 1, 1, 3, ord6(0, 2, 1, 0, 0, 0));
`else
        vt[0] = mkvec(3'b111, 2, 2, 6, ord6(0, 1, 2, 0, 1, 2));
        vt[1] = mkvec(3'b110, 1, 1, 2, ord6(1, 2, 0, 0, 0, 0));
        vt[2] = mkvec(3'b101, 1, 3, 2, ord6(0, 2, 0, 0, 0, 0));
        vt[3] = mkvec(3'b011, 2, 1, 4, ord6(0, 1, 0, 1, 0, 0));
        vt[4] = mkvec(3'b001, 1, 2, 1, ord6(0, 0, 0, 0, 0, 0));
        vt[5] = mkvec(3'b111, 1, 1, 3, ord6(1, 2, 0, 0, 0, 0));
`endif

        checks = 0; failures = 0; fd_count = 0;
        sys_rst_n = 1'b0;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = '0; s_axis_tlast = '0;
        m_axis_tready = 1'b0; mt_rdy = 1'b1; gap = '0; hs = '0;
        sb_on = 1'b0; prev_last = 1'b0;
        for (int i = 0; i < NP; i++) begin src_head[i] = 0; src_tail[i] = 0; exp_stat[i] = 0; end

        tick(); tick();
        chk_zero("por");
        sys_rst_n = 1'b1;
        tick();

        // Reset in the middle of a frame abandons it.
        push_frame(0, 1, 4);
        tick(); tick(); tick();
        chk("midframe_busy", {grant_valid, m_axis_tvalid}, 2'b11);
        async_reset("midframe_rst");
        tick(); tick();
        chk("after_rst_no_tvalid", m_axis_tvalid, 0);
        chk("after_rst_stats", stat_frames, 0);
        chk("after_rst_no_frame_done", fd_count, 0);

        // Single-beat frame on port 1: one bubble cycle, then forwarded.
        sb_on = 1'b1;
        push_beat(1, 64'h1122334455667788, 8'hFF, 1'b1);
        sb_q.push_back('{port: 2'd1, b: '{data: 64'h1122334455667788, keep: 8'hFF, last: 1'b1}});
        tick();
        chk("lat_bubble_m_tvalid", m_axis_tvalid, 0);
        chk("lat_bubble_grant_valid", grant_valid, 0);
        tick();
        chk("lat_first_beat", {m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep},
            {1'b1, 1'b1, 64'h1122334455667788, 8'hFF});
        chk("lat_grant", {grant_valid, grant_idx, s_axis_tready}, {1'b1, 2'd1, 3'b010});
        tick();
        chk("p1_stat_after", stat_frames, 48'h0000_0001_0000);
        chk("p1_grant_idx_held", {grant_valid, grant_idx}, {1'b0, 2'd1});
        tick(); tick();
        chk("p1_frame_done_once", fd_count, 1);
        chk("p1_sb_empty", sb_q.size(), 0);

        async_reset("rst2");

        // Arbitration vectors: all sources offered at once, order checked by scoreboard.
        for (int v = 0; v < 6; v++) begin
            for (int p = 0; p < NP; p++) begin
                cnt[p] = 0;
                if (vt[v].mask[p]) begin
                    for (int f = 0; f < vt[v].nfr; f++) push_frame(p, v*16 + f, vt[v].nb);
                    exp_stat[p] += vt[v].nfr;
                end
            end
            for (int k = 0; k < vt[v].ord_n; k++) begin
                sb_frame(int'(vt[v].ord[k]), v*16 + cnt[vt[v].ord[k]], vt[v].nb);
                cnt[vt[v].ord[k]]++;
            end
            drain($sformatf("vec%0d", v), 200);
            chk_stats($sformatf("vec%0d", v));
        end

        // Port 0 frame under toggling backpressure; port 2 arrives mid-frame.
        push_frame(0, 200, 4);
        sb_frame(0, 200, 4);
        sb_frame(2, 201, 1);
        exp_stat[0]++; exp_stat[2]++;
        for (int c = 0; c < 40; c++) begin
            mt_rdy = (c % 2 == 0);
            tick();
            if (c == 3) push_frame(2, 201, 1);
            if (grant_valid && grant_idx == 2'd0) begin
                chk("bp_port2_not_ready", s_axis_tready[2], 0);
                chk("bp_port0_ready_fwd", s_axis_tready[0], mt_rdy);
            end
            if (c > 6 && sb_q.size() == 0 && !grant_valid) break;
        end
        mt_rdy = 1'b1;
        chk("bp_all_beats_seen", sb_q.size(), 0);
        tick(); tick();
        chk_stats("bp");

        // Granted port drops tvalid for three cycles mid-frame.
        push_frame(1, 300, 4);
        sb_frame(1, 300, 4);
        exp_stat[1]++;
        beats = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (m_axis_tvalid && m_axis_tready && grant_idx == 2'd1) beats++;
            if (beats == 2) break;
        end
        chk("gap_two_beats_seen", beats, 2);
        gap[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("gap%0d_m_tvalid", k), m_axis_tvalid, 0);
            chk($sformatf("gap%0d_grant", k), {grant_valid, grant_idx}, {1'b1, 2'd1});
        end
        gap[1] = 1'b0;
        drain("gap", 50);
        chk_stats("gap");

        // Counter wrap on port 1, starting from a preloaded near-full count.
        force dut.r_stat_frames = 48'h0003_FFFE_0005;
        tick();
        release dut.r_stat_frames;
        tick();
        exp_stat[0] = 5; exp_stat[1] = 16'hFFFE; exp_stat[2] = 3;
        push_frame(1, 400, 1);
        sb_frame(1, 400, 1);
        drain("wrap1", 50);
        chk("wrap_ffff", stat_frames[31:16], 16'hFFFF);
        push_frame(1, 401, 1);
        sb_frame(1, 401, 1);
        drain("wrap2", 50);
        exp_stat[1] = 0;
        chk_stats("wrap");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
